// File: rtl/trainer_vector_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : trainer_vector_sequencer
// Brief    : Debounced button front end and truth-table walker/checker for the
//            gate-selector trainer. TRAINER_SWEEP_EN adds a STEP_DIV timer that
//            advances the walk without button presses.
// Revision : 1.0 - initial release
//==============================================================================
module trainer_vector_sequencer #(
    parameter int DEB_CYCLES = 16,
    parameter int CHECK_LAT  = 1,
    parameter int STEP_DIV   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_step,
    input  logic       btn_mode,
    input  logic       sw_a,
    input  logic       sw_b,
    input  logic [2:0] sw_sel,
    input  logic       gate_y,
    output logic       a_out,
    output logic       b_out,
    output logic [2:0] sel_out,
    output logic       auto_mode,
    output logic       busy,
    output logic       done,
    output logic [4:0] err_cnt,
    output logic       mismatch
);

    localparam int c_DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int c_WAIT_W = (CHECK_LAT > 0) ? $clog2(CHECK_LAT + 1) : 1;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_APPLY = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_CHECK = 3'd3;
    localparam logic [2:0] c_ST_ADV   = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    localparam logic [4:0] c_LAST_IDX = 5'd27;

    if (DEB_CYCLES < 2 || CHECK_LAT < 1 || STEP_DIV < 1) begin : g_param_chk
        $error("trainer_vector_sequencer: parameter out of range");
    end

    // Button debouncers: index 0 = step, index 1 = mode
    logic [1:0] w_btn;
    logic [1:0] w_pulse;
    logic       w_step_p;
    logic       w_mode_p;

    assign w_btn = {btn_mode, btn_step};

    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        logic [1:0]         r_sync;
        logic [c_DEB_W-1:0] r_cnt;
        logic               r_lvl;
        logic               r_lvl_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync  <= 2'b00;
                r_cnt   <= '0;
                r_lvl   <= 1'b0;
                r_lvl_d <= 1'b0;
            end else begin
                r_sync  <= {r_sync[0], w_btn[gi]};
                r_lvl_d <= r_lvl;
                if (r_sync[1] == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DEB_W'(DEB_CYCLES - 1)) begin
                    r_lvl <= r_sync[1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DEB_W'(1);
                end
            end
        end

        assign w_pulse[gi] = r_lvl & ~r_lvl_d;
    end

    assign w_step_p = w_pulse[0];
    assign w_mode_p = w_pulse[1];

    // Walker state; vector index is {sel[2:0], a, b}
    logic [2:0]          r_state, w_state_nxt;
    logic [4:0]          r_idx, w_idx_nxt;
    logic [c_WAIT_W-1:0] r_wait, w_wait_nxt;
    logic [4:0]          r_err, w_err_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_mis, w_mis_nxt;
    logic                r_auto, w_auto_nxt;
    logic                r_a, r_b;
    logic [2:0]          r_sel;
    logic                w_gold;
    logic                w_adv;

`ifdef TRAINER_SWEEP_EN
    localparam int c_TMR_W = $clog2(STEP_DIV + 1);
    logic [c_TMR_W-1:0] r_tmr;

    // Reloaded on the way into ADV, so every advance restarts a full period
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr <= '0;
        end else if (r_state == c_ST_CHECK) begin
            r_tmr <= c_TMR_W'(STEP_DIV - 1);
        end else if (r_state == c_ST_ADV && r_tmr != '0) begin
            r_tmr <= r_tmr - c_TMR_W'(1);
        end
    end

    assign w_adv = w_step_p | (r_tmr == '0);
`else
    assign w_adv = w_step_p;
`endif

    always_comb begin
        w_gold = 1'b0;
        case (r_idx[4:2])
            3'd0:    w_gold = r_idx[1] & r_idx[0];
            3'd1:    w_gold = r_idx[1] | r_idx[0];
            3'd2:    w_gold = ~r_idx[1];
            3'd3:    w_gold = ~(r_idx[1] & r_idx[0]);
            3'd4:    w_gold = ~(r_idx[1] | r_idx[0]);
            3'd5:    w_gold = r_idx[1] ^ r_idx[0];
            3'd6:    w_gold = ~(r_idx[1] ^ r_idx[0]);
            default: w_gold = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wait_nxt  = r_wait;
        w_err_nxt   = r_err;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_mis_nxt   = 1'b0;
        w_auto_nxt  = r_auto;

        if (w_mode_p) begin
            w_auto_nxt  = ~r_auto;
            w_state_nxt = c_ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end else if (r_auto) begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (w_step_p) begin
                        w_err_nxt   = 5'd0;
                        w_idx_nxt   = 5'd0;
                        w_busy_nxt  = 1'b1;
                        w_done_nxt  = 1'b0;
                        w_state_nxt = c_ST_APPLY;
                    end
                end
                c_ST_APPLY: begin
                    w_wait_nxt  = c_WAIT_W'(CHECK_LAT);
                    w_state_nxt = c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    w_wait_nxt = r_wait - c_WAIT_W'(1);
                    if (r_wait <= c_WAIT_W'(1)) begin
                        w_state_nxt = c_ST_CHECK;
                    end
                end
                c_ST_CHECK: begin
                    if (gate_y != w_gold) begin
                        w_mis_nxt = 1'b1;
                        if (r_err != 5'd31) begin
                            w_err_nxt = r_err + 5'd1;
                        end
                    end
                    w_state_nxt = c_ST_ADV;
                end
                c_ST_ADV: begin
                    if (r_idx == c_LAST_IDX) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = c_ST_DONE;
                    end else if (w_adv) begin
                        w_idx_nxt   = r_idx + 5'd1;
                        w_state_nxt = c_ST_APPLY;
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_idx   <= 5'd0;
            r_wait  <= '0;
            r_err   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mis   <= 1'b0;
            r_auto  <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_sel   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_wait  <= w_wait_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_mis   <= w_mis_nxt;
            r_auto  <= w_auto_nxt;
            // Outputs track the next index so the vector is on the pins during APPLY
            if (w_auto_nxt) begin
                {r_sel, r_a, r_b} <= w_idx_nxt;
            end else begin
                {r_sel, r_a, r_b} <= {sw_sel, sw_a, sw_b};
            end
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign sel_out   = r_sel;
    assign auto_mode = r_auto;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_cnt   = r_err;
    assign mismatch  = r_mis;

endmodule
`default_nettype wire

// File: tb/tb_trainer_vector_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_trainer_vector_sequencer
// Brief    : Directed bench for trainer_vector_sequencer (DEB_CYCLES=4,
//            CHECK_LAT=1, STEP_DIV=5). Honours TRAINER_SWEEP_EN.
// Revision : 1.0 - initial release
//==============================================================================
module tb_trainer_vector_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_step, btn_mode;
    logic       sw_a, sw_b;
    logic [2:0] sw_sel;
    logic       gate_y = 1'b0;
    logic       a_out, b_out;
    logic [2:0] sel_out;
    logic       auto_mode, busy, done, mismatch;
    logic [4:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int step_cnt = 0;
    int step_cyc = 0;
    int mis_cnt  = 0;
    int mis_by_sel [0:7] = '{default: 0};
    logic gate_stuck = 1'b0;

    trainer_vector_sequencer #(
        .DEB_CYCLES (4),
        .CHECK_LAT  (1),
        .STEP_DIV   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_step  (btn_step),
        .btn_mode  (btn_mode),
        .sw_a      (sw_a),
        .sw_b      (sw_b),
        .sw_sel    (sw_sel),
        .gate_y    (gate_y),
        .a_out     (a_out),
        .b_out     (b_out),
        .sel_out   (sel_out),
        .auto_mode (auto_mode),
        .busy      (busy),
        .done      (done),
        .err_cnt   (err_cnt),
        .mismatch  (mismatch)
    );

    always #5 clk = ~clk;

    // Gate stage model: one register stage
    function automatic logic gate_fn(input logic [2:0] s, input logic a, input logic b);
        case (s)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        gate_y <= gate_stuck ? 1'b0 : gate_fn(sel_out, a_out, b_out);
        cyc    <= cyc + 1;
    end

    always @(negedge clk) begin
        if (dut.w_step_p) begin
            step_cnt++;
            step_cyc = cyc;
        end
        if (mismatch) begin
            mis_cnt++;
            mis_by_sel[sel_out]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input bit is_mode);
        if (is_mode) btn_mode = 1'b1; else btn_step = 1'b1;
        repeat (8) @(negedge clk);
        if (is_mode) btn_mode = 1'b0; else btn_step = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_walk();
        press(1'b0);
        check("walk_busy", busy, 1);
`ifdef TRAINER_SWEEP_EN
        for (int i = 0; i < 28 * 9 && !done; i++) @(negedge clk);
`else
        repeat (27) press(1'b0);
`endif
    endtask

    int base_step, t0, base_mis;
    int base_sel [0:7];

    initial begin
        rst = 1'b1; btn_step = 1'b0; btn_mode = 1'b0;
        sw_a = 1'b0; sw_b = 1'b0; sw_sel = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_a", a_out, 0);
        check("rst_b", b_out, 0);
        check("rst_sel", sel_out, 0);
        check("rst_auto", auto_mode, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_cnt, 0);
        check("rst_mis", mismatch, 0);
        rst = 1'b0;

        // Manual pass-through, one cycle latency
        sw_a = 1'b1; sw_b = 1'b0; sw_sel = 3'd3;
        @(negedge clk);
        check("man_a", a_out, 1);
        check("man_b", b_out, 0);
        check("man_sel", sel_out, 3);

        // Bouncing step button: 3-cycle glitches must not pass
        base_step = step_cnt;
        repeat (3) begin
            btn_step = 1'b1; repeat (3) @(negedge clk);
            btn_step = 1'b0; repeat (3) @(negedge clk);
        end
        check("deb_glitch", step_cnt - base_step, 0);
        btn_step = 1'b1;
        t0 = cyc;
        repeat (10) @(negedge clk);
        check("deb_one_pulse", step_cnt - base_step, 1);
        check("deb_latency", step_cyc - t0, 6);
        btn_step = 1'b0;
        repeat (10) @(negedge clk);
        check("man_step_a", a_out, 1);
        check("man_step_sel", sel_out, 3);
        check("man_step_busy", busy, 0);

        // Enter auto mode, full walk with a correct gate
        press(1'b1);
        check("auto_on", auto_mode, 1);
        base_mis = mis_cnt;
        run_walk();
        check("walk_done", done, 1);
        check("walk_busy_end", busy, 0);
        check("walk_err", err_cnt, 0);
        check("walk_mis", mis_cnt - base_mis, 0);
        check("walk_last_vec", {sel_out, a_out, b_out}, 5'd27);

        // Stuck-at-0 gate: restart from DONE
        gate_stuck = 1'b1;
        base_mis = mis_cnt;
        base_sel = mis_by_sel;
        run_walk();
        check("stuck_done", done, 1);
        check("stuck_err", err_cnt, 14);
        check("stuck_mis", mis_cnt - base_mis, 14);
        check("stuck_and",  mis_by_sel[0] - base_sel[0], 1);
        check("stuck_or",   mis_by_sel[1] - base_sel[1], 3);
        check("stuck_not",  mis_by_sel[2] - base_sel[2], 2);
        check("stuck_nand", mis_by_sel[3] - base_sel[3], 3);
        check("stuck_nor",  mis_by_sel[4] - base_sel[4], 1);
        check("stuck_xor",  mis_by_sel[5] - base_sel[5], 2);
        check("stuck_xnor", mis_by_sel[6] - base_sel[6], 2);

        // Mode change clears done but keeps the error count
        press(1'b1);
        check("mode_off_auto", auto_mode, 0);
        check("mode_off_done", done, 0);
        check("mode_off_err", err_cnt, 14);
        press(1'b1);
        check("mode_on_again", auto_mode, 1);

        // Reset in the middle of the walk at vector 10
`ifdef TRAINER_SWEEP_EN
        press(1'b0);
        for (int i = 0; i < 200 && {sel_out, a_out, b_out} != 5'd10; i++) @(negedge clk);
        check("mid_vec", {sel_out, a_out, b_out}, 5'd10);
`else
        repeat (11) press(1'b0);
        check("mid_vec", {sel_out, a_out, b_out}, 5'd10);
        check("mid_err", err_cnt, 6);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_a", a_out, 0);
        check("mrst_b", b_out, 0);
        check("mrst_sel", sel_out, 0);
        check("mrst_auto", auto_mode, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_err", err_cnt, 0);
        check("mrst_mis", mismatch, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
